// File: rtl/counter_pkg.sv
// Shared counter definitions: overflow mode constants and the load clamp helper.
// Purely combinational helpers, no state.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Loaded values above the terminal count are pinned to it so the count never leaves range.
  function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/counter_next_value.sv
// Next-count and bound-event logic for a bounded up/down counter.
// Combinational, zero latency; no flow control.
module counter_next_value
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 9,
  parameter logic [WIDTH-1:0] MAX_COUNT = '1,
  parameter int               SATURATE  = CNT_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] next_count,
  output logic             bound_hit
);

  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;
  logic           at_bound;

  always_comb begin
    inc        = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
    dec        = {1'b0, count} - {{WIDTH{1'b0}}, 1'b1};
    // The guard bit exposes both bounds: overshoot past MAX_COUNT going up, borrow going down.
    at_bound   = up ? (inc > {1'b0, MAX_COUNT}) : dec[WIDTH];
    bound_hit  = enable & at_bound;
    next_count = count;
    if (enable) begin
      if (!at_bound) begin
        next_count = up ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
      end else if (SATURATE != CNT_SAT) begin
        next_count = up ? '0 : MAX_COUNT;
      end
    end
  end

endmodule

// File: rtl/counter_mod_nbit.sv
// Parametrised modulo counter with load, sync clear, terminal count, carry pulse and sticky overflow.
// One clk from controls to count; tc is combinational; always accepts inputs (no backpressure).
module counter_mod_nbit
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 9,
  parameter logic [WIDTH-1:0] MAX_COUNT = '1,
  parameter int               SATURATE  = CNT_WRAP
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry,
  output logic             ovf
);

  logic             rst_meta;
  logic [WIDTH-1:0] next_count;
  logic             bound_hit;
  logic [WIDTH-1:0] load_clamped;

  counter_next_value #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .SATURATE  (SATURATE)
  ) u_next (
    .count      (count),
    .enable     (enable),
    .up         (up),
    .next_count (next_count),
    .bound_hit  (bound_hit)
  );

  assign tc           = bound_hit;
  assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MAX_COUNT)));

  // Release synchroniser: rst_meta is the first stage and the state registers below,
  // which only update once rst_meta is high, form the second stage.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      rst_meta <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (rst_meta) begin
      if (sync_clr) begin
        count <= '0;
        carry <= 1'b0;
        ovf   <= 1'b0;
      end else if (load) begin
        count <= load_clamped;
        carry <= 1'b0;
      end else begin
        count <= next_count;
        carry <= bound_hit;
        if (bound_hit) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_mod_nbit.sv
// Bench for counter_mod_nbit: three instances share stimulus; a scoreboard queue feeds a monitor.
// dut0: W9/M15/wrap, dut1: W9/M9/saturate, dut2: W9/M255/wrap.
module tb_counter_mod_nbit;

  typedef struct {
    int         dut;
    logic [8:0] count;
    logic       tc;
    logic       carry;
    logic       ovf;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       sync_clr = 1'b0;
  logic       load = 1'b0;
  logic [8:0] load_val = '0;
  logic       enable = 1'b0;
  logic       up = 1'b0;

  logic [8:0] count0, count1, count2;
  logic       tc0, tc1, tc2;
  logic       carry0, carry1, carry2;
  logic       ovf0, ovf1, ovf2;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  counter_mod_nbit #(.WIDTH(9), .MAX_COUNT(9'd15), .SATURATE(0)) dut0 (
    .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load), .load_val(load_val),
    .enable(enable), .up(up), .count(count0), .tc(tc0), .carry(carry0), .ovf(ovf0));

  counter_mod_nbit #(.WIDTH(9), .MAX_COUNT(9'd9), .SATURATE(1)) dut1 (
    .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load), .load_val(load_val),
    .enable(enable), .up(up), .count(count1), .tc(tc1), .carry(carry1), .ovf(ovf1));

  counter_mod_nbit #(.WIDTH(9), .MAX_COUNT(9'd255), .SATURATE(0)) dut2 (
    .clk(clk), .clear_n(clear_n), .sync_clr(sync_clr), .load(load), .load_val(load_val),
    .enable(enable), .up(up), .count(count2), .tc(tc2), .carry(carry2), .ovf(ovf2));

  task automatic drive(input logic sc, input logic ld, input logic [8:0] lv,
                       input logic en, input logic u);
    @(negedge clk);
    sync_clr = sc;
    load     = ld;
    load_val = lv;
    enable   = en;
    up       = u;
  endtask

  task automatic expect_out(input int d, input logic [8:0] c, input logic t,
                            input logic ca, input logic o, input string nm);
    exp_t e;
    e.dut = d; e.count = c; e.tc = t; e.carry = ca; e.ovf = o; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: drains every pending expectation shortly after each edge or reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge clear_n);
      #1;
      while (sb.size() != 0) begin
        exp_t e;
        logic [8:0] ac;
        logic at, aca, ao;
        e = sb.pop_front();
        case (e.dut)
          0:       begin ac = count0; at = tc0; aca = carry0; ao = ovf0; end
          1:       begin ac = count1; at = tc1; aca = carry1; ao = ovf1; end
          default: begin ac = count2; at = tc2; aca = carry2; ao = ovf2; end
        endcase
        total++;
        if (ac !== e.count || at !== e.tc || aca !== e.carry || ao !== e.ovf) begin
          bad++;
          $display("FAIL %s dut%0d: got count=%0d tc=%b carry=%b ovf=%b, want count=%0d tc=%b carry=%b ovf=%b",
                   e.name, e.dut, ac, at, aca, ao, e.count, e.tc, e.carry, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while clear_n held low across an edge.
    drive(0, 0, 9'd0, 1, 1);
    expect_out(0, 9'd0, 0, 0, 0, "reset0");
    expect_out(1, 9'd0, 0, 0, 0, "reset1");
    expect_out(2, 9'd0, 0, 0, 0, "reset2");

    // Release between edges: first edge holds, counting starts on the second.
    drive(0, 0, 9'd0, 1, 1);
    clear_n = 1'b1;
    expect_out(0, 9'd0, 0, 0, 0, "a_rel_edge1");
    for (int i = 1; i <= 17; i++) begin
      drive(0, 0, 9'd0, 1, 1);
      expect_out(0, 9'(i % 16), (i == 15), (i == 16), (i >= 16), "a_up_wrap");
    end

    // Count down through zero.
    drive(1, 0, 9'd0, 1, 0);
    expect_out(0, 9'd0, 1, 0, 0, "b_clr");
    drive(0, 0, 9'd0, 1, 0);
    expect_out(0, 9'd15, 0, 1, 1, "b_down_wrap");
    drive(0, 0, 9'd0, 1, 0);
    expect_out(0, 9'd14, 0, 0, 1, "b_down_step");
    drive(0, 0, 9'd0, 0, 0);
    expect_out(0, 9'd14, 0, 0, 1, "b_hold");

    // Saturating instance held at the bound.
    drive(1, 0, 9'd0, 0, 1);
    expect_out(1, 9'd0, 0, 0, 0, "c_clr0");
    drive(0, 1, 9'd9, 0, 1);
    expect_out(1, 9'd9, 0, 0, 0, "c_load9");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 9'd0, 1, 1);
      expect_out(1, 9'd9, 1, 1, 1, "c_sat_hold");
    end
    drive(1, 0, 9'd0, 0, 1);
    expect_out(1, 9'd0, 0, 0, 0, "c_sync_clr");
    drive(0, 1, 9'd300, 0, 1);
    expect_out(1, 9'd9, 0, 0, 0, "c_clamp");
    drive(1, 0, 9'd0, 0, 1);
    expect_out(1, 9'd0, 0, 0, 0, "c_clr1");

    // Load above MAX with enable set: clamp, no step.
    drive(0, 1, 9'd300, 1, 1);
    expect_out(2, 9'd255, 1, 0, 0, "d_load_clamp");
    drive(0, 0, 9'd0, 1, 1);
    expect_out(2, 9'd0, 0, 1, 1, "d_wrap");
    drive(0, 1, 9'd100, 1, 1);
    expect_out(2, 9'd100, 0, 0, 1, "d_load_keep_ovf");

    // dut0 now holds 15 with ovf set; bring it to 7 then reset mid-cycle.
    drive(0, 1, 9'd5, 0, 1);
    expect_out(0, 9'd5, 0, 0, 1, "e_load5");
    drive(0, 0, 9'd0, 1, 1);
    expect_out(0, 9'd6, 0, 0, 1, "e_step6");
    drive(0, 0, 9'd0, 1, 1);
    expect_out(0, 9'd7, 0, 0, 1, "e_step7");
    @(posedge clk);
    #2;
    expect_out(0, 9'd0, 0, 0, 0, "e_async0");
    expect_out(2, 9'd0, 0, 0, 0, "e_async2");
    clear_n = 1'b0;
    drive(0, 0, 9'd0, 1, 1);
    expect_out(0, 9'd0, 0, 0, 0, "e_held");
    drive(0, 0, 9'd0, 1, 1);
    clear_n = 1'b1;
    expect_out(0, 9'd0, 0, 0, 0, "e_rel_edge1");
    drive(0, 0, 9'd0, 1, 1);
    expect_out(0, 9'd1, 0, 0, 0, "e_rel_edge2");
    drive(0, 0, 9'd0, 1, 1);
    expect_out(0, 9'd2, 0, 0, 0, "e_rel_edge3");

    drive(0, 0, 9'd0, 0, 1);
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
